apb_wwdt_mc: RTL and testbench
==============================

APB_WWDT_MC -- requirements
Module: apb_wwdt_mc

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent watchdog channels (legal range 1..8).
REQ-002 SHALL have parameter CW, default 16, counter/load/window width in bits (legal range 8..32).
REQ-003 SHALL have port pclk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port prstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port paddr  input  8  APB byte address.
REQ-006 SHALL have ports psel, penable, pwrite  input  1 each  APB control.
REQ-007 SHALL have port pwdata  input  32  write data.
REQ-008 SHALL have port prdata  output  32  read data.
REQ-009 SHALL have ports pready, pslverr  output  1 each  APB completion and error.
REQ-010 SHALL have port wdt_intr  output  NCH  per-channel interrupt, level.
REQ-011 SHALL have port wdt_rst_req  output  1  sticky system reset request.

Function
REQ-012 SHALL decode the register map as: channel c base = 0x10*c; CTRL +0x0, LOAD +0x4, WINDOW +0x8, COUNT +0xC (RO); global KICK 0x80 (WO), STATUS 0x84 (W1C), ID 0x88 (RO, value {16'h5744, 8'(NCH), 8'(CW)}).
REQ-013 SHALL implement CTRL bits: [0] en, [1] intr_en, [2] rst_en, [3] win_en; bits [31:4] read 0.
REQ-014 SHALL write a register only in the access phase (psel & penable & pwrite); pready = 1 always (zero wait states).
REQ-015 SHALL drive prdata combinationally from the addressed register during psel & !pwrite, 0 otherwise; LOAD/WINDOW/COUNT bits above CW read 0, written bits above CW are discarded.
REQ-016 SHALL assert pslverr in the access phase for an unmapped address, a channel base >= NCH, a write to COUNT/ID or a read of KICK; an erroring access changes no state.
REQ-017 SHALL load COUNT from LOAD on the cycle after en goes 0->1; COUNT holds while en = 0.
REQ-018 SHALL decrement COUNT by 1 per pclk while en = 1 and COUNT != 0.
REQ-019 SHALL treat a KICK write with pwdata[31:16] = 16'hA55A as a refresh of every enabled channel c where pwdata[c] = 1; other KICK data is ignored without pslverr.
REQ-020 SHALL, on refresh of channel c, reload COUNT from LOAD the next cycle, unless win_en = 1 and COUNT > WINDOW (early kick).
REQ-021 SHALL, on early kick, set STATUS.early[c] (bit 8+c), not reload, and assert wdt_rst_req next cycle if rst_en = 1.
REQ-022 SHALL, when COUNT = 0 with en = 1, set STATUS.to[c] (bit c) and reload from LOAD; if STATUS.to[c] was already 1 at that edge and rst_en = 1, assert wdt_rst_req (two-stage timeout).
REQ-023 SHALL drive wdt_intr[c] = intr_en[c] & (STATUS.to[c] | STATUS.early[c]).
REQ-024 SHALL resolve simultaneous events: valid refresh and COUNT = 0 in the same cycle -> refresh wins, no timeout; W1C clear and a new set of the same STATUS bit -> set wins.
REQ-025 SHALL let a LOAD write during counting take effect only at the next reload; LOAD = 0 SHALL cause a timeout every cycle while enabled.
REQ-026 SHALL hold wdt_rst_req at 1 until prstn is asserted; no register write clears it.

Reset
REQ-027 SHALL, on a pclk edge with prstn = 0, clear CTRL, LOAD, WINDOW, COUNT, STATUS and wdt_rst_req to 0, including mid-count; wdt_intr = 0, prdata = 0, pslverr = 0, pready = 1 during and after reset.

Verification
REQ-028 SHALL check: ch0 LOAD=10, CTRL=0x3, no kick -> STATUS bit0 set and wdt_intr[0]=1 exactly 11 cycles after COUNT load; wdt_rst_req stays 0.
REQ-029 SHALL check: ch1 LOAD=20, WINDOW=5, CTRL=0xF, KICK 0xA55A0002 at COUNT=12 -> STATUS bit9 set, wdt_rst_req=1 next cycle; repeat with KICK at COUNT=3 -> COUNT=20 next cycle, no flags.
REQ-030 SHALL check: ch0 CTRL=0x5, LOAD=4, STATUS bit0 not cleared -> second expiry asserts wdt_rst_req; clearing bit0 via STATUS write 0x1 between expiries -> no request.
REQ-031 SHALL check: KICK at the cycle COUNT=0 -> no STATUS.to, COUNT reloads; W1C of bit0 on the cycle of a new timeout -> bit0 remains 1.
REQ-032 SHALL check: read 0x40 with NCH=4 and write COUNT -> pslverr=1, no state change; read 0x88 with defaults -> 0x57440410.
REQ-033 SHALL check: prstn=0 for one edge while ch0 counting at COUNT=7 and wdt_rst_req=1 -> all registers 0, wdt_intr=0, wdt_rst_req=0 next cycle.

Source files
------------

// File: rtl/apb_wwdt_mc.sv
// ---------------------------------------------------------------------------
// apb_wwdt_mc -- multi-channel windowed watchdog timer with an APB slave port
//
// Each of NCH channels has its own down-counter that reloads from LOAD. A
// channel expiring (COUNT reaches 0 while enabled) sets STATUS.to; if it
// expires again while STATUS.to is still set and rst_en is on, a sticky
// system reset request is raised. With win_en set, a refresh kick that
// arrives while COUNT is still above WINDOW is an early kick: it is flagged
// and does not reload.
//
// Ports:
//   pclk         clock, all logic on the rising edge
//   prstn        synchronous active-low reset
//   paddr        APB byte address (8 bits)
//   psel/penable/pwrite, pwdata  APB request
//   prdata       APB read data (combinational)
//   pready       always 1 (no wait states)
//   pslverr      error on unmapped/illegal access (access phase only)
//   wdt_intr     per-channel level interrupt
//   wdt_rst_req  sticky reset request, cleared only by prstn
//
// Register map: channel c at 0x10*c: CTRL +0x0, LOAD +0x4, WINDOW +0x8,
// COUNT +0xC (RO). Global: KICK 0x80 (WO), STATUS 0x84 (W1C), ID 0x88 (RO).
// ---------------------------------------------------------------------------
module apb_wwdt_mc #(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic           pclk,
    input  logic           prstn,
    input  logic [7:0]     paddr,
    input  logic           psel,
    input  logic           penable,
    input  logic           pwrite,
    input  logic [31:0]    pwdata,
    output logic [31:0]    prdata,
    output logic           pready,
    output logic           pslverr,
    output logic [NCH-1:0] wdt_intr,
    output logic           wdt_rst_req
);

    localparam logic [31:0] ID_VALUE = {16'h5744, 8'(NCH), 8'(CW)};
    localparam logic [3:0]  NCH_U    = 4'(NCH);

    logic [NCH-1:0][3:0]    ctrl;
    logic [NCH-1:0][CW-1:0] load;
    logic [NCH-1:0][CW-1:0] window;
    logic [NCH-1:0][CW-1:0] count;
    logic [NCH-1:0]         en_prev;
    logic [NCH-1:0]         st_to;
    logic [NCH-1:0]         st_early;
    logic                   rst_req;

    logic [2:0] ch;
    logic [3:0] off;
    logic       ch_space, ch_valid;
    logic       hit_ctrl, hit_load, hit_win, hit_count;
    logic       hit_kick, hit_status, hit_id;
    logic       mapped, access, bad_access, wr_ok, kick_ok;

    logic [NCH-1:0] sel, start, kick, early_kick, refresh, timeout;
    logic [NCH-1:0] clr_to, clr_early;
    logic           rst_set;

    // Address decode. Channel space is the lower half of the map; a
    // channel index at or above NCH is treated as unmapped.
    assign ch       = paddr[6:4];
    assign off      = paddr[3:0];
    assign ch_space = ~paddr[7];
    assign ch_valid = ({1'b0, ch} < NCH_U);

    assign hit_ctrl   = ch_space & ch_valid & (off == 4'h0);
    assign hit_load   = ch_space & ch_valid & (off == 4'h4);
    assign hit_win    = ch_space & ch_valid & (off == 4'h8);
    assign hit_count  = ch_space & ch_valid & (off == 4'hC);
    assign hit_kick   = (paddr == 8'h80);
    assign hit_status = (paddr == 8'h84);
    assign hit_id     = (paddr == 8'h88);
    assign mapped     = hit_ctrl | hit_load | hit_win | hit_count |
                        hit_kick | hit_status | hit_id;

    assign access     = psel & penable;
    assign bad_access = ~mapped | (pwrite & (hit_count | hit_id)) | (~pwrite & hit_kick);
    assign pslverr    = prstn & access & bad_access;
    assign wr_ok      = prstn & access & pwrite & ~bad_access;
    assign pready     = 1'b1;

    // A kick only counts with the 0xA55A key in the upper half-word.
    assign kick_ok = wr_ok & hit_kick & (pwdata[31:16] == 16'hA55A);

    // Per-channel event resolution. Priority: enable-edge load, then a
    // valid refresh, then expiry. A refresh on the expiry cycle therefore
    // suppresses the timeout. Kicks landing on the enable-edge cycle are
    // absorbed by that load.
    always_comb begin
        sel        = '0;
        start      = '0;
        kick       = '0;
        early_kick = '0;
        refresh    = '0;
        timeout    = '0;
        rst_set    = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            sel[c]        = (ch == 3'(c));
            start[c]      = ctrl[c][0] & ~en_prev[c];
            kick[c]       = kick_ok & pwdata[c] & ctrl[c][0] & ~start[c];
            early_kick[c] = kick[c] & ctrl[c][3] & (count[c] > window[c]);
            refresh[c]    = kick[c] & ~early_kick[c];
            timeout[c]    = ctrl[c][0] & ~start[c] & ~refresh[c] & (count[c] == '0);
            // Second expiry with STATUS.to still pending, or an early kick,
            // escalates to a system reset request when rst_en is set.
            if (ctrl[c][2] & ((timeout[c] & st_to[c]) | early_kick[c]))
                rst_set = 1'b1;
        end
    end

    // W1C masks for STATUS: to in [NCH-1:0], early in [8+NCH-1:8].
    assign clr_to    = (wr_ok & hit_status) ? pwdata[NCH-1:0]  : '0;
    assign clr_early = (wr_ok & hit_status) ? pwdata[8 +: NCH] : '0;

    // Register file and counters. New STATUS sets are OR-ed in after the
    // W1C mask so a set in the same cycle as a clear survives.
    always_ff @(posedge pclk) begin
        if (!prstn) begin
            ctrl     <= '0;
            load     <= '0;
            window   <= '0;
            count    <= '0;
            en_prev  <= '0;
            st_to    <= '0;
            st_early <= '0;
            rst_req  <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (wr_ok & hit_ctrl & sel[c])
                    ctrl[c] <= pwdata[3:0];
                if (wr_ok & hit_load & sel[c])
                    load[c] <= pwdata[CW-1:0];
                if (wr_ok & hit_win & sel[c])
                    window[c] <= pwdata[CW-1:0];
                en_prev[c] <= ctrl[c][0];
                if (start[c] | refresh[c] | timeout[c])
                    count[c] <= load[c];
                else if (ctrl[c][0] && (count[c] != '0))
                    count[c] <= count[c] - CW'(1);
            end
            st_to    <= (st_to & ~clr_to) | timeout;
            st_early <= (st_early & ~clr_early) | early_kick;
            if (rst_set)
                rst_req <= 1'b1;
        end
    end

    // Read mux: only during a read transfer, and never while in reset.
    always_comb begin
        prdata = '0;
        if (prstn & psel & ~pwrite) begin
            if (hit_status) begin
                prdata[NCH-1:0]  = st_to;
                prdata[8 +: NCH] = st_early;
            end else if (hit_id) begin
                prdata = ID_VALUE;
            end
            for (int c = 0; c < NCH; c++) begin
                if (sel[c]) begin
                    if (hit_ctrl)  prdata = 32'(ctrl[c]);
                    if (hit_load)  prdata = 32'(load[c]);
                    if (hit_win)   prdata = 32'(window[c]);
                    if (hit_count) prdata = 32'(count[c]);
                end
            end
        end
    end

    always_comb begin
        wdt_intr = '0;
        for (int c = 0; c < NCH; c++)
            wdt_intr[c] = ctrl[c][1] & (st_to[c] | st_early[c]);
    end

    assign wdt_rst_req = rst_req;

endmodule

// File: tb/tb_apb_wwdt_mc.sv
// ---------------------------------------------------------------------------
// tb_apb_wwdt_mc -- directed self-checking bench for apb_wwdt_mc (NCH=4,
// CW=16). Each scenario task drives APB traffic and compares observed
// values against hand-computed expectations.
//
// Cycle bookkeeping: E0 is the access edge of the CTRL write that sets en.
// COUNT is loaded at E1, so COUNT after Ek is LOAD-(k-1) until expiry.
// apb_write started just after edge Ex has its access edge at Ex+2;
// apb_read started just after Ex samples prdata as it stands after Ex+1.
// ---------------------------------------------------------------------------
module tb_apb_wwdt_mc;

    logic        pclk = 1'b0;
    logic        prstn = 1'b0;
    logic [7:0]  paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [3:0]  wdt_intr;
    logic        wdt_rst_req;

    int          total = 0;
    int          bad = 0;
    logic [31:0] rd;
    logic        err;

    apb_wwdt_mc #(.NCH(4), .CW(16)) dut (
        .pclk        (pclk),
        .prstn       (prstn),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .wdt_intr    (wdt_intr),
        .wdt_rst_req (wdt_rst_req)
    );

    always #5 pclk = ~pclk;

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e);
        @(negedge pclk);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        #1 e = pslverr;
        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
        @(negedge pclk);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        d = prdata;
        e = pslverr;
        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_reset();
        prstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (2) @(posedge pclk);
        #1 prstn = 1'b1;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        prstn = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h40;
        @(posedge pclk);
        @(negedge pclk);
        penable = 1'b1;
        #1;
        total++; if (pslverr !== 1'b0) begin bad++; $display("[TB] FAIL rst_pslverr: got %b want 0", pslverr); end
        total++; if (prdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_prdata: got %h want 0", prdata); end
        total++; if (pready !== 1'b1) begin bad++; $display("[TB] FAIL rst_pready: got %b want 1", pready); end
        @(posedge pclk);
        #1;
        total++; if (wdt_intr !== 4'h0) begin bad++; $display("[TB] FAIL rst_intr: got %h want 0", wdt_intr); end
        total++; if (wdt_rst_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_req: got %b want 0", wdt_rst_req); end
        psel = 1'b0; penable = 1'b0; prstn = 1'b1;
        apb_read(8'h00, rd, err);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL rst_ctrl: got %h want 0", rd); end
        apb_read(8'h84, rd, err);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL rst_status: got %h want 0", rd); end
    endtask

    task automatic test_timeout();
        do_reset();
        apb_write(8'h04, 32'd10, err);
        apb_write(8'h00, 32'h3, err);      // E0
        apb_read(8'h0C, rd, err);          // samples after E1
        total++; if (rd !== 32'd10) begin bad++; $display("[TB] FAIL to_count_load: got %0d want 10", rd); end
        wait_edges(9);                     // after E11
        total++; if (wdt_intr !== 4'b0000) begin bad++; $display("[TB] FAIL to_intr_early: got %b want 0000", wdt_intr); end
        wait_edges(1);                     // after E12: expiry
        total++; if (wdt_intr !== 4'b0001) begin bad++; $display("[TB] FAIL to_intr: got %b want 0001", wdt_intr); end
        apb_read(8'h84, rd, err);
        total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL to_status: got %h want 1", rd); end
        apb_read(8'h0C, rd, err);          // after E15: 10,9,8,7
        total++; if (rd !== 32'd7) begin bad++; $display("[TB] FAIL to_reload: got %0d want 7", rd); end
        total++; if (wdt_rst_req !== 1'b0) begin bad++; $display("[TB] FAIL to_no_req: got %b want 0", wdt_rst_req); end
    endtask

    task automatic test_window();
        do_reset();
        apb_write(8'h14, 32'd20, err);
        apb_write(8'h18, 32'd5, err);
        apb_write(8'h10, 32'hF, err);      // E0
        wait_edges(8);
        apb_write(8'h80, 32'hA55A0002, err); // access E10, COUNT=12 before it
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL win_kick_err: got %b want 0", err); end
        total++; if (wdt_rst_req !== 1'b1) begin bad++; $display("[TB] FAIL win_early_req: got %b want 1", wdt_rst_req); end
        total++; if (wdt_intr !== 4'b0010) begin bad++; $display("[TB] FAIL win_early_intr: got %b want 0010", wdt_intr); end
        apb_read(8'h84, rd, err);
        total++; if (rd !== 32'h200) begin bad++; $display("[TB] FAIL win_early_status: got %h want 200", rd); end
        apb_read(8'h1C, rd, err);          // no reload: 11,10,9,8 after E13
        total++; if (rd !== 32'd8) begin bad++; $display("[TB] FAIL win_early_count: got %0d want 8", rd); end

        do_reset();
        apb_write(8'h14, 32'd20, err);
        apb_write(8'h18, 32'd5, err);
        apb_write(8'h10, 32'hF, err);      // E0
        wait_edges(17);
        apb_write(8'h80, 32'hA55A0002, err); // access E19, COUNT=3 before it
        apb_read(8'h1C, rd, err);          // reload 20 at E19, 19 after E20
        total++; if (rd !== 32'd19) begin bad++; $display("[TB] FAIL win_ok_count: got %0d want 19", rd); end
        total++; if (wdt_rst_req !== 1'b0) begin bad++; $display("[TB] FAIL win_ok_req: got %b want 0", wdt_rst_req); end
        apb_read(8'h84, rd, err);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL win_ok_status: got %h want 0", rd); end
    endtask

    task automatic test_two_stage();
        do_reset();
        apb_write(8'h04, 32'd4, err);
        apb_write(8'h00, 32'h5, err);      // E0, expiries at E6 and E11
        wait_edges(10);
        total++; if (wdt_rst_req !== 1'b0) begin bad++; $display("[TB] FAIL two_pre_req: got %b want 0", wdt_rst_req); end
        wait_edges(1);
        total++; if (wdt_rst_req !== 1'b1) begin bad++; $display("[TB] FAIL two_req: got %b want 1", wdt_rst_req); end
        apb_read(8'h84, rd, err);
        total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL two_status: got %h want 1", rd); end

        do_reset();
        apb_write(8'h04, 32'd4, err);
        apb_write(8'h00, 32'h5, err);      // E0
        wait_edges(6);
        apb_read(8'h84, rd, err);          // after E7
        total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL two_first_to: got %h want 1", rd); end
        apb_write(8'h84, 32'h1, err);      // clear at E10
        wait_edges(1);                     // after E11
        total++; if (wdt_rst_req !== 1'b0) begin bad++; $display("[TB] FAIL two_clr_req: got %b want 0", wdt_rst_req); end
        apb_read(8'h84, rd, err);
        total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL two_clr_status: got %h want 1", rd); end
    endtask

    task automatic test_kick_at_zero();
        do_reset();
        apb_write(8'h04, 32'd4, err);
        apb_write(8'h00, 32'h1, err);      // E0
        wait_edges(4);
        apb_write(8'h80, 32'hA55A0001, err); // access E6 with COUNT=0
        apb_read(8'h84, rd, err);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL kz_status: got %h want 0", rd); end
        apb_read(8'h0C, rd, err);          // 4,3,2,1 after E9
        total++; if (rd !== 32'd1) begin bad++; $display("[TB] FAIL kz_count: got %0d want 1", rd); end

        do_reset();
        apb_write(8'h04, 32'd4, err);
        apb_write(8'h00, 32'h1, err);      // E0, expiries at E6 and E11
        wait_edges(9);
        apb_write(8'h84, 32'h1, err);      // W1C at E11
        apb_read(8'h84, rd, err);
        total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL kz_set_wins: got %h want 1", rd); end
    endtask

    task automatic test_load_update();
        do_reset();
        apb_write(8'h34, 32'd3, err);
        apb_write(8'h30, 32'h1, err);      // E0
        apb_write(8'h34, 32'd8, err);      // E2
        apb_read(8'h3C, rd, err);          // after E3
        total++; if (rd !== 32'd1) begin bad++; $display("[TB] FAIL ld_hold: got %0d want 1", rd); end
        wait_edges(1);                     // E5 expiry reloads 8
        apb_read(8'h3C, rd, err);
        total++; if (rd !== 32'd7) begin bad++; $display("[TB] FAIL ld_new: got %0d want 7", rd); end
    endtask

    task automatic test_errors();
        do_reset();
        apb_read(8'h40, rd, err);
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_ch4_rd: got %b want 1", err); end
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL err_ch4_data: got %h want 0", rd); end
        apb_write(8'h04, 32'hFFFF1234, err);
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL err_load_wr: got %b want 0", err); end
        apb_write(8'h44, 32'h0000ABCD, err);
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_ch4_wr: got %b want 1", err); end
        apb_read(8'h04, rd, err);
        total++; if (rd !== 32'h1234) begin bad++; $display("[TB] FAIL err_load_rd: got %h want 1234", rd); end
        apb_write(8'h0C, 32'h55, err);
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_count_wr: got %b want 1", err); end
        apb_read(8'h0C, rd, err);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL err_count_kept: got %h want 0", rd); end
        apb_read(8'h88, rd, err);
        total++; if (rd !== 32'h57440410) begin bad++; $display("[TB] FAIL err_id: got %h want 57440410", rd); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL err_id_err: got %b want 0", err); end
        apb_read(8'h80, rd, err);
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_kick_rd: got %b want 1", err); end
        apb_write(8'h88, 32'h0, err);
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_id_wr: got %b want 1", err); end
        apb_read(8'h02, rd, err);
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_unaligned: got %b want 1", err); end
        apb_write(8'h00, 32'hFFFFFFF6, err);
        apb_read(8'h00, rd, err);
        total++; if (rd !== 32'h6) begin bad++; $display("[TB] FAIL err_ctrl_mask: got %h want 6", rd); end
        apb_write(8'h80, 32'h12340001, err);
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL err_badkey: got %b want 0", err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        apb_write(8'h20, 32'h7, err);      // ch2, LOAD=0: expires every cycle
        apb_write(8'h04, 32'd20, err);
        apb_write(8'h00, 32'h5, err);      // E0 for ch0
        apb_read(8'h0C, rd, err);          // after E1
        total++; if (rd !== 32'd20) begin bad++; $display("[TB] FAIL mid_count: got %0d want 20", rd); end
        wait_edges(12);                    // after E14, ch0 COUNT=7
        total++; if (wdt_rst_req !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_req: got %b want 1", wdt_rst_req); end
        total++; if (wdt_intr !== 4'b0100) begin bad++; $display("[TB] FAIL mid_pre_intr: got %b want 0100", wdt_intr); end
        prstn = 1'b0;
        @(posedge pclk);
        #1;
        total++; if (wdt_rst_req !== 1'b0) begin bad++; $display("[TB] FAIL mid_req: got %b want 0", wdt_rst_req); end
        total++; if (wdt_intr !== 4'b0000) begin bad++; $display("[TB] FAIL mid_intr: got %b want 0", wdt_intr); end
        total++; if (pready !== 1'b1) begin bad++; $display("[TB] FAIL mid_pready: got %b want 1", pready); end
        prstn = 1'b1;
        apb_read(8'h0C, rd, err);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL mid_count0: got %h want 0", rd); end
        apb_read(8'h04, rd, err);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL mid_load0: got %h want 0", rd); end
        apb_read(8'h20, rd, err);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL mid_ctrl2: got %h want 0", rd); end
        apb_read(8'h84, rd, err);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL mid_status: got %h want 0", rd); end
        total++; if (wdt_rst_req !== 1'b0) begin bad++; $display("[TB] FAIL mid_req_after: got %b want 0", wdt_rst_req); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_window();
        test_two_stage();
        test_kick_at_zero();
        test_load_update();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "[TB] time limit");
    end

endmodule
